// File: rtl/shifter_pkg.sv
//------------------------------------------------------------------------------
// Module   : shifter_pkg
// Purpose  : Mode encodings and reserved-mode decode for the pipelined shifter.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package shifter_pkg;

    localparam int SH_MODE_W = 3;

    localparam logic [SH_MODE_W-1:0] SH_SLL = 3'b000;
    localparam logic [SH_MODE_W-1:0] SH_SRL = 3'b001;
    localparam logic [SH_MODE_W-1:0] SH_SRA = 3'b010;
    localparam logic [SH_MODE_W-1:0] SH_ROL = 3'b011;
    localparam logic [SH_MODE_W-1:0] SH_ROR = 3'b100;

    function automatic logic sh_is_reserved(input logic [SH_MODE_W-1:0] mode);
        return (mode > SH_ROR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/shift_stage.sv
//------------------------------------------------------------------------------
// Module   : shift_stage
// Purpose  : One log-shifter stage: conditional move by DIST plus pipeline register.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TAG_W   = 5,
    parameter int SHAMT_W = 5,
    parameter int DIST    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [SHAMT_W-1:0]   in_shamt,
    input  logic [SH_MODE_W-1:0] in_mode,
    input  logic                 in_sign,
    input  logic                 in_illegal,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SHAMT_W-1:0]   out_shamt,
    output logic [SH_MODE_W-1:0] out_mode,
    output logic                 out_sign,
    output logic                 out_illegal,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int c_bit_idx = $clog2(DIST);

    logic                 r_valid;
    logic [WIDTH-1:0]     r_data;
    logic [SHAMT_W-1:0]   r_shamt;
    logic [SH_MODE_W-1:0] r_mode;
    logic                 r_sign;
    logic                 r_illegal;
    logic [TAG_W-1:0]     r_tag;

    logic [WIDTH-1:0]     w_moved;
    logic [WIDTH-1:0]     w_next;
    logic                 w_load;

    // SRA fills from the sign captured at entry, never from the shifted data.
    always_comb begin
        w_moved = in_data;
        case (in_mode)
            SH_SLL:  w_moved = {in_data[WIDTH-DIST-1:0], {DIST{1'b0}}};
            SH_SRL:  w_moved = {{DIST{1'b0}}, in_data[WIDTH-1:DIST]};
            SH_SRA:  w_moved = {{DIST{in_sign}}, in_data[WIDTH-1:DIST]};
            SH_ROL:  w_moved = {in_data[WIDTH-DIST-1:0], in_data[WIDTH-1:WIDTH-DIST]};
            SH_ROR:  w_moved = {in_data[DIST-1:0], in_data[WIDTH-1:DIST]};
            default: w_moved = in_data;
        endcase
        w_next = in_shamt[c_bit_idx] ? w_moved : in_data;
    end

    assign w_load   = rst_n && !flush && (!r_valid || out_ready);
    assign in_ready = w_load;

    // Empty slots load zeros so invalid payload never shows at the outputs.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_shamt   <= '0;
            r_mode    <= '0;
            r_sign    <= 1'b0;
            r_illegal <= 1'b0;
            r_tag     <= '0;
        end else if (w_load) begin
            r_valid   <= in_valid;
            r_data    <= in_valid ? w_next     : '0;
            r_shamt   <= in_valid ? in_shamt   : '0;
            r_mode    <= in_valid ? in_mode    : '0;
            r_sign    <= in_valid ? in_sign    : 1'b0;
            r_illegal <= in_valid ? in_illegal : 1'b0;
            r_tag     <= in_valid ? in_tag     : '0;
        end
    end

    assign out_valid   = r_valid;
    assign out_data    = r_data;
    assign out_shamt   = r_shamt;
    assign out_mode    = r_mode;
    assign out_sign    = r_sign;
    assign out_illegal = r_illegal;
    assign out_tag     = r_tag;

endmodule

`default_nettype wire

// File: rtl/pipelined_shifter.sv
//------------------------------------------------------------------------------
// Module   : pipelined_shifter
// Purpose  : Pipelined logarithmic SLL/SRL/SRA/ROL/ROR with valid/ready and tag.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [SHAMT_W-1:0]   in_shamt,
    input  logic [SH_MODE_W-1:0] in_mode,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_result,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 out_illegal
);

    // Index k feeds stage k; index SHAMT_W is the last stage's registers.
    logic                 w_valid   [SHAMT_W+1];
    logic [WIDTH-1:0]     w_data    [SHAMT_W+1];
    logic [SHAMT_W-1:0]   w_shamt   [SHAMT_W+1];
    logic [SH_MODE_W-1:0] w_mode    [SHAMT_W+1];
    logic                 w_sign    [SHAMT_W+1];
    logic                 w_illegal [SHAMT_W+1];
    logic [TAG_W-1:0]     w_tag     [SHAMT_W+1];

    assign w_valid[0]   = in_valid;
    assign w_data[0]    = in_a;
    assign w_shamt[0]   = in_shamt;
    assign w_mode[0]    = in_mode;
    assign w_sign[0]    = in_a[WIDTH-1];
    assign w_illegal[0] = sh_is_reserved(in_mode);
    assign w_tag[0]     = in_tag;

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        logic w_rdy;
        logic w_down_rdy;

        if (k == SHAMT_W-1) begin : g_last
            assign w_down_rdy = out_ready;
        end else begin : g_mid
            assign w_down_rdy = g_stage[k+1].w_rdy;
        end

        shift_stage #(
            .WIDTH   (WIDTH),
            .TAG_W   (TAG_W),
            .SHAMT_W (SHAMT_W),
            .DIST    (1 << k)
        ) u_stage (
            .clk         (clk),
            .rst_n       (rst_n),
            .flush       (flush),
            .in_valid    (w_valid[k]),
            .in_ready    (w_rdy),
            .in_data     (w_data[k]),
            .in_shamt    (w_shamt[k]),
            .in_mode     (w_mode[k]),
            .in_sign     (w_sign[k]),
            .in_illegal  (w_illegal[k]),
            .in_tag      (w_tag[k]),
            .out_valid   (w_valid[k+1]),
            .out_ready   (w_down_rdy),
            .out_data    (w_data[k+1]),
            .out_shamt   (w_shamt[k+1]),
            .out_mode    (w_mode[k+1]),
            .out_sign    (w_sign[k+1]),
            .out_illegal (w_illegal[k+1]),
            .out_tag     (w_tag[k+1])
        );
    end

    assign in_ready    = g_stage[0].w_rdy;
    assign out_valid   = w_valid[SHAMT_W];
    assign out_result  = w_data[SHAMT_W];
    assign out_tag     = w_tag[SHAMT_W];
    assign out_illegal = w_illegal[SHAMT_W];

    logic w_unused_tail;
    assign w_unused_tail = ^{w_shamt[SHAMT_W], w_mode[SHAMT_W], w_sign[SHAMT_W]};

endmodule

`default_nettype wire

// File: tb/tb_pipelined_shifter.sv
//------------------------------------------------------------------------------
// Module   : tb_pipelined_shifter
// Purpose  : Self-checking bench for 32-bit and 8-bit pipelined_shifter instances.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipelined_shifter;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        logic        ill;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush     [2] = '{1'b0, 1'b0};
    logic        in_valid  [2] = '{1'b0, 1'b0};
    logic [31:0] in_a      [2] = '{32'd0, 32'd0};
    logic [4:0]  in_shamt  [2] = '{5'd0, 5'd0};
    logic [2:0]  in_mode   [2] = '{3'd0, 3'd0};
    logic [4:0]  in_tag    [2] = '{5'd0, 5'd0};
    logic        out_ready [2] = '{1'b1, 1'b1};
    logic        rdy_level [2] = '{1'b1, 1'b1};
    logic        rnd_mode  [2] = '{1'b0, 1'b0};

    logic        in_ready    [2];
    logic        out_valid   [2];
    logic [31:0] out_result  [2];
    logic [4:0]  out_tag     [2];
    logic        out_illegal [2];

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    exp_t exp_q [2][$];
    logic prev_rst = 1'b0;
    logic prev_flush [2] = '{1'b0, 1'b0};
    logic hold_pend  [2] = '{1'b0, 1'b0};
    logic [37:0] hold_val [2];
    int   last_stall [2] = '{-1, -1};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int W  = (g == 0) ? 32 : 8;
        localparam int SW = $clog2(W);
        logic         w_rdy, w_ov, w_ill;
        logic [W-1:0] w_res;
        logic [4:0]   w_tag;

        pipelined_shifter #(.WIDTH(W), .TAG_W(5)) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .flush       (flush[g]),
            .in_valid    (in_valid[g]),
            .in_ready    (w_rdy),
            .in_a        (in_a[g][W-1:0]),
            .in_shamt    (in_shamt[g][SW-1:0]),
            .in_mode     (in_mode[g]),
            .in_tag      (in_tag[g]),
            .out_valid   (w_ov),
            .out_ready   (out_ready[g]),
            .out_result  (w_res),
            .out_tag     (w_tag),
            .out_illegal (w_ill)
        );

        assign in_ready[g]    = w_rdy;
        assign out_valid[g]   = w_ov;
        assign out_result[g]  = 32'(w_res);
        assign out_tag[g]     = w_tag;
        assign out_illegal[g] = w_ill;
    end

    // Reference: shift/rotate of a w-bit value computed on a 64-bit canvas.
    function automatic logic [31:0] model(int w, logic [31:0] a, int sh, logic [2:0] m);
        logic [63:0] mask;
        logic [63:0] x;
        logic [63:0] r;
        mask = (64'd1 << w) - 64'd1;
        x    = {32'd0, a} & mask;
        case (m)
            3'd0:    r = x << sh;
            3'd1:    r = x >> sh;
            3'd2:    r = (x >> sh) | (x[w-1] ? (mask & ~(mask >> sh)) : 64'd0);
            3'd3:    r = (x << sh) | (x >> (w - sh));
            3'd4:    r = (x >> sh) | (x << (w - sh));
            default: r = x;
        endcase
        return 32'(r & mask);
    endfunction

    task automatic chk(input int i, input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL inst%0d %s: got %h expected %h (t=%0t)", i, nm, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #2;
        for (int i = 0; i < 2; i++)
            out_ready[i] = rnd_mode[i] ? ($urandom_range(0, 3) != 0) : rdy_level[i];
    end

    // Single compare process: everything sampled at the falling edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            int   w;
            int   sw;
            exp_t e;
            logic exp_rdy;
            w  = (i == 0) ? 32 : 8;
            sw = (i == 0) ? 5 : 3;

            if (rst_n && !prev_rst) begin
                chk(i, "release_in_ready", 64'(in_ready[i]), 64'd1);
                chk(i, "release_out_valid", 64'(out_valid[i]), 64'd0);
            end
            if (prev_flush[i])
                chk(i, "post_flush_out_valid", 64'(out_valid[i]), 64'd0);

            exp_rdy = rst_n && !flush[i] && ((exp_q[i].size() < sw) || out_ready[i]);
            chk(i, "in_ready", 64'(in_ready[i]), 64'(exp_rdy));

            if (out_valid[i] !== 1'b1)
                chk(i, "idle_outputs", 64'({out_result[i], out_tag[i], out_illegal[i]}), 64'd0);

            if (hold_pend[i]) begin
                chk(i, "hold_valid", 64'(out_valid[i]), 64'd1);
                chk(i, "hold_payload", 64'({out_result[i], out_tag[i], out_illegal[i]}), 64'(hold_val[i]));
            end

            if (out_valid[i] === 1'b1) begin
                if (exp_q[i].size() == 0) begin
                    chk(i, "spurious_out_valid", 64'(out_valid[i]), 64'd0);
                end else begin
                    e = exp_q[i][0];
                    chk(i, "result", 64'(out_result[i]), 64'(e.res));
                    chk(i, "tag", 64'(out_tag[i]), 64'(e.tag));
                    chk(i, "illegal", 64'(out_illegal[i]), 64'(e.ill));
                    if (last_stall[i] < e.acc)
                        chk(i, "latency", 64'(cyc - e.acc), 64'(sw));
                    if (out_ready[i] && rst_n && !flush[i])
                        void'(exp_q[i].pop_front());
                end
            end

            hold_pend[i] = rst_n && !flush[i] && (out_valid[i] === 1'b1) && !out_ready[i];
            hold_val[i]  = {out_result[i], out_tag[i], out_illegal[i]};
            if (!out_ready[i])
                last_stall[i] = cyc;

            if (!rst_n || flush[i]) begin
                exp_q[i].delete();
            end else if (in_valid[i] && in_ready[i]) begin
                e.res = model(w, in_a[i], int'(in_shamt[i]) & (w - 1), in_mode[i]);
                e.tag = in_tag[i];
                e.ill = (in_mode[i] > 3'd4);
                e.acc = cyc;
                exp_q[i].push_back(e);
            end
            prev_flush[i] = flush[i] && rst_n;
        end
        prev_rst = rst_n;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int i, input logic [31:0] a, input int sh, input logic [2:0] m,
                         input logic [4:0] t);
        bit acc;
        int n;
        n = 0;
        in_valid[i] = 1'b1;
        in_a[i]     = a;
        in_shamt[i] = 5'(sh);
        in_mode[i]  = m;
        in_tag[i]   = t;
        do begin
            @(negedge clk);
            acc = in_ready[i];
            tick();
            n++;
        end while (!acc && n < 200);
        if (!acc) chk(i, "offer_timeout", 64'd0, 64'd1);
        in_valid[i] = 1'b0;
    endtask

    task automatic drain(input int i);
        int n;
        n = 0;
        while (exp_q[i].size() != 0 && n < 500) begin
            tick();
            n++;
        end
        if (exp_q[i].size() != 0) chk(i, "drain_timeout", 64'(exp_q[i].size()), 64'd0);
        repeat (2) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        chk(0, "pin_sll", 64'(model(32, 32'h0000_0001, 31, 3'd0)), 64'h8000_0000);
        chk(0, "pin_srl", 64'(model(32, 32'h8000_0000, 31, 3'd1)), 64'h0000_0001);
        chk(0, "pin_sra_neg", 64'(model(32, 32'h8000_0000, 4, 3'd2)), 64'hF800_0000);
        chk(0, "pin_sra_pos", 64'(model(32, 32'h7000_0000, 4, 3'd2)), 64'h0700_0000);
        chk(0, "pin_ror", 64'(model(32, 32'h0000_00F1, 4, 3'd4)), 64'h1000_000F);
        chk(0, "pin_rol", 64'(model(32, 32'h8000_0001, 1, 3'd3)), 64'h0000_0003);
        chk(0, "pin_reserved", 64'(model(32, 32'hDEAD_BEEF, 7, 3'd7)), 64'hDEAD_BEEF);
        chk(1, "pin_rol8", 64'(model(8, 32'h81, 7, 3'd3)), 64'hC0);

        offer(0, 32'h0000_0001, 31, 3'd0, 5'd1);
        offer(0, 32'h8000_0000, 31, 3'd1, 5'd2);
        offer(0, 32'h8000_0000, 4, 3'd2, 5'd3);
        offer(0, 32'h7000_0000, 4, 3'd2, 5'd4);
        offer(0, 32'h0000_00F1, 4, 3'd4, 5'd5);
        offer(0, 32'h8000_0001, 1, 3'd3, 5'd6);
        offer(0, 32'hDEAD_BEEF, 7, 3'd7, 5'd7);
        offer(0, 32'h1234_5678, 0, 3'd0, 5'd8);
        offer(0, 32'h1234_5678, 0, 3'd2, 5'd9);
        drain(0);
        offer(1, 32'h81, 7, 3'd3, 5'd10);
        drain(1);

        fork
            begin
                for (int t = 0; t < 10; t++)
                    offer(0, $urandom, $urandom_range(0, 31), 3'($urandom_range(0, 4)), 5'(t));
            end
            begin
                repeat (6) @(posedge clk);
                rdy_level[0] = 1'b0;
                repeat (3) @(posedge clk);
                rdy_level[0] = 1'b1;
            end
        join
        drain(0);

        for (int t = 0; t < 4; t++)
            offer(0, $urandom, $urandom_range(0, 31), 3'($urandom_range(0, 4)), 5'(20 + t));
        in_valid[0] = 1'b1;
        in_a[0]     = 32'hCAFE_F00D;
        in_tag[0]   = 5'd30;
        flush[0]    = 1'b1;
        tick();
        flush[0]    = 1'b0;
        in_valid[0] = 1'b0;
        repeat (10) tick();

        for (int t = 0; t < 4; t++)
            offer(0, $urandom, $urandom_range(0, 31), 3'($urandom_range(0, 4)), 5'(24 + t));
        in_valid[0] = 1'b1;
        in_tag[0]   = 5'd31;
        rst_n       = 1'b0;
        tick();
        rst_n       = 1'b1;
        in_valid[0] = 1'b0;
        repeat (10) tick();

        rnd_mode[0] = 1'b1;
        rnd_mode[1] = 1'b1;
        fork
            begin
                for (int n = 0; n < 1000; n++) begin
                    if ($urandom_range(0, 3) == 0) tick();
                    offer(1, $urandom, $urandom_range(0, 7), 3'($urandom_range(0, 7)), 5'($urandom));
                end
            end
            begin
                for (int n = 0; n < 300; n++) begin
                    if ($urandom_range(0, 3) == 0) tick();
                    offer(0, $urandom, $urandom_range(0, 31), 3'($urandom_range(0, 7)), 5'($urandom));
                end
            end
        join
        rnd_mode[0] = 1'b0;
        rnd_mode[1] = 1'b0;
        drain(0);
        drain(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
